// File: rtl/cpu_regfile.sv
// Architectural register file: X,Y,A,PClo,PChi,Mlo,Mhi,SP with combinational write-through reads,
// hardware PC increment/load and SP push/pop with a registered wrap pulse.
module cpu_regfile #(
    parameter int                  DATA_W   = 8,
    parameter int                  NUM_RD   = 2,
    parameter logic [DATA_W-1:0]   SP_RESET = DATA_W'('hFF),
    parameter logic [2*DATA_W-1:0] PC_RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [2:0]                 waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [3*NUM_RD-1:0]        raddr,
    output logic [DATA_W*NUM_RD-1:0]   rdata,
    input  logic                       pc_inc,
    input  logic                       pc_load,
    input  logic [2*DATA_W-1:0]        pc_load_val,
    input  logic [1:0]                 sp_op,
    output logic [2*DATA_W-1:0]        pc,
    output logic [DATA_W-1:0]          sp,
    output logic                       sp_wrap
);

    localparam logic [2:0] R_X    = 3'd0;
    localparam logic [2:0] R_Y    = 3'd1;
    localparam logic [2:0] R_A    = 3'd2;
    localparam logic [2:0] R_PCLO = 3'd3;
    localparam logic [2:0] R_PCHI = 3'd4;
    localparam logic [2:0] R_MLO  = 3'd5;
    localparam logic [2:0] R_MHI  = 3'd6;
    localparam logic [2:0] R_SP   = 3'd7;

    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    localparam logic [2*DATA_W-1:0] PC_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   SP_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]   x_q, x_d, y_q, y_d, a_q, a_d, mlo_q, mlo_d, mhi_q, mhi_d;
    logic [2*DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0]   sp_q, sp_d;
    logic                sp_wrap_q, sp_wrap_d;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        a_d   = a_q;
        mlo_d = mlo_q;
        mhi_d = mhi_q;
        if (we) begin
            case (waddr)
                R_X:     x_d   = wdata;
                R_Y:     y_d   = wdata;
                R_A:     a_d   = wdata;
                R_MLO:   mlo_d = wdata;
                R_MHI:   mhi_d = wdata;
                default: ;
            endcase
        end
    end

    // PC: full load beats a byte write, which beats the increment.
    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_load_val;
        end else if (we && waddr == R_PCLO) begin
            pc_d[DATA_W-1:0] = wdata;
        end else if (we && waddr == R_PCHI) begin
            pc_d[2*DATA_W-1:DATA_W] = wdata;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // SP: a direct write wins over push/pop and never reports a wrap.
    always_comb begin
        sp_d      = sp_q;
        sp_wrap_d = 1'b0;
        if (we && waddr == R_SP) begin
            sp_d = wdata;
        end else if (sp_op == SP_PUSH) begin
            sp_d      = sp_q - SP_ONE;
            sp_wrap_d = (sp_q == '0);
        end else if (sp_op == SP_POP) begin
            sp_d      = sp_q + SP_ONE;
            sp_wrap_d = (sp_q == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            a_q       <= '0;
            mlo_q     <= '0;
            mhi_q     <= '0;
            pc_q      <= PC_RESET;
            sp_q      <= SP_RESET;
            sp_wrap_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            a_q       <= a_d;
            mlo_q     <= mlo_d;
            mhi_q     <= mhi_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            sp_wrap_q <= sp_wrap_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [2:0]        ra;
        logic [DATA_W-1:0] stored;

        assign ra = raddr[3*i +: 3];

        always_comb begin
            stored = '0;
            case (ra)
                R_X:    stored = x_q;
                R_Y:    stored = y_q;
                R_A:    stored = a_q;
                R_PCLO: stored = pc_q[DATA_W-1:0];
                R_PCHI: stored = pc_q[2*DATA_W-1:DATA_W];
                R_MLO:  stored = mlo_q;
                R_MHI:  stored = mhi_q;
                R_SP:   stored = sp_q;
            endcase
        end

        // Write-through so a reader in the same cycle sees the value being written.
        assign rdata[DATA_W*i +: DATA_W] = (we && waddr == ra) ? wdata : stored;
    end

    assign pc      = pc_q;
    assign sp      = sp_q;
    assign sp_wrap = sp_wrap_q;

endmodule

// File: tb/tb_cpu_regfile.sv
// Scoreboard bench for cpu_regfile: the driver pushes per-cycle expectations from an
// arithmetic register model; a negedge monitor pops and compares reads, pc, sp and sp_wrap.
module tb_cpu_regfile;

    localparam logic [2:0] RX = 3'd0, RY = 3'd1, RA = 3'd2, RPL = 3'd3;
    localparam logic [2:0] RPH = 3'd4, RML = 3'd5, RMH = 3'd6, RSP = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [5:0]  raddr;
    logic [15:0] rdata;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [1:0]  sp_op;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic        sp_wrap;

    cpu_regfile dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .sp_op(sp_op), .pc(pc), .sp(sp), .sp_wrap(sp_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rd0;
        logic [7:0]  rd1;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: general registers in an array, PC and SP as plain integers.
    logic [7:0]  m_reg [0:7];
    int unsigned m_pc;
    int unsigned m_sp;
    logic        m_wrap;

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            RPL:     return 8'(m_pc % 256);
            RPH:     return 8'(m_pc / 256);
            RSP:     return 8'(m_sp);
            default: return m_reg[a];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_pc   = 0;
        m_sp   = 255;
        m_wrap = 1'b0;
    endtask

    task automatic model_clock(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                               input logic pi, input logic pl, input logic [15:0] plv,
                               input logic [1:0] so);
        if (w && (wa == RX || wa == RY || wa == RA || wa == RML || wa == RMH)) m_reg[wa] = wd;
        if (pl)                    m_pc = plv;
        else if (w && wa == RPL)   m_pc = (m_pc / 256) * 256 + wd;
        else if (w && wa == RPH)   m_pc = wd * 256 + (m_pc % 256);
        else if (pi)               m_pc = (m_pc + 1) % 65536;
        m_wrap = 1'b0;
        if (w && wa == RSP) begin
            m_sp = wd;
        end else if (so == 2'b01) begin
            m_wrap = (m_sp == 0);
            m_sp   = (m_sp + 255) % 256;
        end else if (so == 2'b10) begin
            m_wrap = (m_sp == 255);
            m_sp   = (m_sp + 1) % 256;
        end
    endtask

    task automatic drive_push(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                              input logic [2:0] r0, input logic [2:0] r1,
                              input logic pi, input logic pl, input logic [15:0] plv,
                              input logic [1:0] so);
        exp_t e;
        we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
        pc_inc = pi; pc_load = pl; pc_load_val = plv; sp_op = so;
        e.rd0  = (w && wa == r0) ? wd : model_read(r0);
        e.rd1  = (w && wa == r1) ? wd : model_read(r1);
        e.pc   = 16'(m_pc);
        e.sp   = 8'(m_sp);
        e.wrap = m_wrap;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] r0, input logic [2:0] r1,
                        input logic pi, input logic pl, input logic [15:0] plv,
                        input logic [1:0] so);
        drive_push(w, wa, wd, r0, r1, pi, pl, plv, so);
        if (rst_n) model_clock(w, wa, wd, pi, pl, plv, so);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [2:0] r0, input logic [2:0] r1);
        step(1'b0, RX, 8'h00, r0, r1, 1'b0, 1'b0, 16'h0000, 2'b00);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata0", {8'h00, rdata[7:0]}, {8'h00, e.rd0});
                chk("rdata1", {8'h00, rdata[15:8]}, {8'h00, e.rd1});
                chk("pc", pc, e.pc);
                chk("sp", {8'h00, sp}, {8'h00, e.sp});
                chk("sp_wrap", {15'h0, sp_wrap}, {15'h0, e.wrap});
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = '0; sp_op = '0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset values of every readable register.
        idle(RX, RY);
        idle(RA, RML);
        idle(RMH, RSP);
        rst_n = 1'b1;

        // Write-through then held value.
        step(1'b1, RA, 8'h5A, RA, RX, 1'b0, 1'b0, 16'h0, 2'b00);
        idle(RA, RA);

        // PC carry and full wrap.
        step(1'b0, RX, 8'h00, RPL, RPH, 1'b0, 1'b1, 16'h00FF, 2'b00);
        step(1'b0, RX, 8'h00, RPL, RPH, 1'b1, 1'b0, 16'h0000, 2'b00);
        idle(RPL, RPH);
        step(1'b0, RX, 8'h00, RPL, RPH, 1'b0, 1'b1, 16'hFFFF, 2'b00);
        step(1'b0, RX, 8'h00, RPL, RPH, 1'b1, 1'b0, 16'h0000, 2'b00);
        idle(RPL, RPH);

        // PC priority.
        step(1'b0, RX, 8'h00, RPL, RPH, 1'b0, 1'b1, 16'h1234, 2'b00);
        step(1'b1, RPL, 8'h77, RPL, RPH, 1'b1, 1'b0, 16'h0000, 2'b00);
        step(1'b1, RPL, 8'h77, RPL, RPH, 1'b1, 1'b1, 16'hABCD, 2'b00);
        step(1'b1, RPH, 8'h9C, RPH, RPL, 1'b1, 1'b0, 16'h0000, 2'b00);
        idle(RPL, RPH);

        // SP wrap on push and pop.
        step(1'b1, RSP, 8'h00, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b00);
        step(1'b0, RX, 8'h00, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b01);
        step(1'b0, RX, 8'h00, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b10);
        idle(RSP, RX);
        idle(RSP, RX);

        // SP priority and reserved op.
        step(1'b1, RSP, 8'h10, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b00);
        step(1'b1, RSP, 8'h40, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b01);
        step(1'b0, RX, 8'h00, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b11);
        step(1'b1, RSP, 8'h00, RSP, RX, 1'b0, 1'b0, 16'h0, 2'b01);
        idle(RSP, RX);

        // Random traffic with edge values for wdata.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] wd;
            int sel;
            sel = int'($urandom_range(0, 9));
            wd  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 16'($urandom), 2'($urandom_range(0, 3)));
        end

        // Reset arriving mid-cycle discards the pending writes, increment and push.
        drive_push(1'b1, RX, 8'hEE, RX, RSP, 1'b1, 1'b0, 16'h0, 2'b01);
        #6;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle(RX, RY);
        idle(RA, RML);
        idle(RMH, RSP);
        rst_n = 1'b1;
        idle(RX, RSP);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
